// File: rtl/fdiv_seq_ctrl.sv
// Multi-cycle binary32 divider sequencer: restoring 1-bit-per-cycle mantissa divide under an FSM.
// Optional round-to-nearest-even build: define FDIV_ROUND_EN (adds a guard iteration and sticky).
module fdiv_seq_ctrl #(
  parameter int ITER_BITS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        flag_dz,
  output logic        flag_of,
  output logic        flag_uf
);

`ifdef FDIV_ROUND_EN
  localparam int QW = ITER_BITS + 1;
`else
  localparam int QW = ITER_BITS;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, ITER, NORM, DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [24:0]        rem_q, rem_d, div_q, div_d;
  logic [QW-1:0]      quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [31:0]        result_q, result_d;
  logic               dz_q, dz_d, of_q, of_d, uf_q, uf_d;

  logic [22:0]        mant;
  logic signed [9:0]  exp_n;

  function automatic logic [23:0] round_rne(input logic [22:0] m, input logic g, input logic s);
    return {1'b0, m} + 24'(g & (s | m[0]));
  endfunction

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    dz_d     = dz_q;
    of_d     = of_q;
    uf_d     = uf_q;
    mant     = '0;
    exp_n    = exp_q;

    // Normalisation: the quotient of two 1.x mantissas lies in [0.5, 2), so at most one shift.
`ifdef FDIV_ROUND_EN
    begin
      logic [23:0] rnd;
      if (quo_q[QW-1])
        rnd = round_rne(quo_q[QW-2:2], quo_q[1], quo_q[0] | (rem_q != '0));
      else begin
        rnd   = round_rne(quo_q[QW-3:1], quo_q[0], rem_q != '0);
        exp_n = exp_q - 10'sd1;
      end
      mant = rnd[22:0];
      if (rnd[23]) exp_n = exp_n + 10'sd1;
    end
`else
    if (quo_q[QW-1]) begin
      mant = quo_q[QW-2:1];
    end else begin
      mant  = quo_q[QW-3:0];
      exp_n = exp_q - 10'sd1;
    end
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          dz_d    = 1'b0;
          of_d    = 1'b0;
          uf_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        sign_d = a_q[31] ^ b_q[31];
        exp_d  = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
        rem_d  = {2'b01, a_q[22:0]};
        div_d  = {2'b01, b_q[22:0]};
        quo_d  = '0;
        cnt_d  = '0;
        if (b_q[30:23] == 8'd0) begin
          result_d = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
          dz_d     = 1'b1;
          state_d  = DONE;
        end else if (a_q[30:23] == 8'd0) begin
          result_d = {a_q[31] ^ b_q[31], 31'd0};
          state_d  = DONE;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        if (rem_q >= div_q) begin
          quo_d = {quo_q[QW-2:0], 1'b1};
          rem_d = (rem_q - div_q) << 1;
        end else begin
          quo_d = {quo_q[QW-2:0], 1'b0};
          rem_d = rem_q << 1;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(QW - 1)) state_d = NORM;
      end
      NORM: begin
        if (exp_n >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          of_d     = 1'b1;
        end else if (exp_n <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
          uf_d     = 1'b1;
        end else begin
          result_d = {sign_q, exp_n[7:0], mant};
        end
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      dz_q     <= 1'b0;
      of_q     <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      dz_q     <= dz_d;
      of_q     <= of_d;
      uf_q     <= uf_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign flag_dz = dz_q;
  assign flag_of = of_q;
  assign flag_uf = uf_q;

endmodule

// File: tb/tb_fdiv_seq_ctrl.sv
// Directed bench for fdiv_seq_ctrl: arithmetic cases, special operands, handshake and async reset.
`timescale 1ns/1ps
module tb_fdiv_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, flag_dz, flag_of, flag_uf;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

`ifdef FDIV_ROUND_EN
  localparam int LAT = 29;
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam int LAT = 28;
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  fdiv_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result),
    .flag_dz(flag_dz), .flag_of(flag_of), .flag_uf(flag_uf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic dz, input logic of, input logic uf,
                        input int lat);
    int n;
    n = 0;
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy_start"}, 32'(busy), 32'd1);
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin n = i; break; end
    end
    chk({tag, ".latency"}, 32'(n), 32'(lat));
    chk({tag, ".result"}, result, er);
    chk({tag, ".flags"}, {29'd0, flag_dz, flag_of, flag_uf}, {29'd0, dz, of, uf});
    chk({tag, ".busy_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    chk({tag, ".result_held"}, result, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount, dfirst;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.flags", {29'd0, flag_dz, flag_of, flag_uf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("6div2",   32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, LAT);
    run_op("1div3",   32'h3F800000, 32'h40400000, THIRD,        1'b0, 1'b0, 1'b0, LAT);
    run_op("m10div5", 32'hC1200000, 32'h40A00000, 32'hC0000000, 1'b0, 1'b0, 1'b0, LAT);
    run_op("1div0",   32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 1'b0, 2);
    run_op("ovf",     32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 1'b1, 1'b0, LAT);
    run_op("unf",     32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b0, 1'b1, LAT);
    run_op("0divm2",  32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 2);
    run_op("dz_after_uf", 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0, 1'b0, 2);

    // Handshake: start held during cycles 5..20 with other operands must be ignored
    dcount = 0; dfirst = 0;
    @(negedge clk);
    op_a = 32'h40C00000; op_b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dcount++;
        if (dfirst == 0) dfirst = i;
      end
      if (i == 4) begin op_a = 32'h3F800000; op_b = 32'h40400000; start = 1'b1; end
      if (i == 20) start = 1'b0;
    end
    chk("hs.done_count", 32'(dcount), 32'd1);
    chk("hs.latency", 32'(dfirst), 32'(LAT));
    chk("hs.result", result, 32'h40400000);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    op_a = 32'h3F800000; op_b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.done", 32'(done), 32'd0);
    chk("arst.result", result, 32'd0);
    chk("arst.flags", {29'd0, flag_dz, flag_of, flag_uf}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
      if (i == 2) rst = 1'b0;
    end
    chk("arst.no_done", 32'(dcount), 32'd0);
    run_op("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fdiv_seq_ctrl.md
Name: fdiv_seq_ctrl

Overview:
- Multi-cycle sequencer for single-precision (IEEE-754 binary32) division in the RV32IMF FPU.
- Replaces the single-cycle combinational mantissa divide with a 1-bit-per-cycle restoring divider driven by an FSM.
- Uses a start/busy/done handshake towards the execute stage, which stalls while busy=1.
- Handles sign, exponent bias, normalisation and special operands. Results are truncated by default.

Parameters:
- ITER_BITS, 25, number of quotient bits produced (1 integer bit + 24 fraction bits). Fixed for binary32; not meant to be overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- op_a  input  32  dividend (binary32)
- op_b  input  32  divisor (binary32)
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; result/flags valid
- result  output  32  quotient; held until the next accepted start
- flag_dz  output  1  divide-by-zero (valid with done, held)
- flag_of  output  1  exponent overflow (valid with done, held)
- flag_uf  output  1  exponent underflow (flushed to zero)

Behaviour:
- Reset values: busy=0, done=0, result=0, all flags 0, FSM in IDLE. Reset is asynchronous, active-high and clock-independent. Asserting reset mid-operation aborts immediately; no done is produced.
- Operand classes:
  - A zero/denormal operand has exponent field 0 and is treated as zero (flush).
  - Inf/NaN (exponent 255) is not specially decoded; it is processed arithmetically.
- FSM states: IDLE, LOAD, ITER, NORM, DONE.
- IDLE:
  - start=1 latches op_a/op_b and moves to LOAD; busy goes high on the next edge.
  - start while busy=1 is ignored; no queueing.
- LOAD:
  - sign = a[31]^b[31].
  - exp = a_exp - b_exp + 127, held in a 10-bit signed register.
  - rem = {1,a_frac} in a 25-bit register; div = {1,b_frac}; counter = 0.
  - If b_exp==0: result = {sign, 0xFF, 0}, flag_dz=1, go to DONE.
  - Else if a_exp==0: result = {sign, 0, 0}, go to DONE.
  - Else go to ITER.
- ITER:
  - Each cycle: if rem >= div, then q = {q[23:0],1} and rem = (rem-div)<<1; else q = {q[23:0],0} and rem = rem<<1.
  - Runs exactly ITER_BITS cycles (counter 0..24), then goes to NORM.
- NORM:
  - If q[24]=1: mantissa = q[23:1], exp unchanged.
  - If q[24]=0: mantissa = q[22:0], exp = exp-1. The quotient of 1.x/1.x is in [0.5,2), so one shift is always sufficient.
  - If exp >= 255: result = {sign, 0xFF, 0}, flag_of=1.
  - Else if exp <= 0: result = {sign, 0, 0}, flag_uf=1.
  - Else result = {sign, exp[7:0], mantissa}.
  - Go to DONE.
- DONE:
  - done=1 for one cycle; busy falls on the same edge done rises.
  - Go to IDLE. A start in the DONE cycle is ignored; a new start is accepted from IDLE.
- Flags are cleared on every accepted start.
- Latency, counting from the edge that samples start=1 (edge 0):
  - Normal path: done is high in the cycle after edge 28 (LOAD 1 + ITER 25 + NORM 1 + DONE entry).
  - Special-operand path: done is high after edge 2.
- Counter and remainder widths must not overflow: rem < 2*div always holds, so 25 bits suffice.

Optional Feature:
- Macro FDIV_ROUND_EN.
- Defined:
  - ITER runs 26 cycles; the extra bit is the guard bit. Sticky = (final rem != 0).
  - Round-to-nearest-even is applied in NORM. A mantissa carry-out increments exp, and the overflow check is applied after rounding.
  - Normal-path done moves to after edge 29.
- Undefined: truncation as above, 25 iterations.

Test Plan:
- 6.0/2.0: op_a=0x40C00000, op_b=0x40000000, start pulse -> done after edge 28, result=0x40400000, flags 0.
- 1.0/3.0: 0x3F800000/0x40400000 -> result=0x3EAAAAAA. With FDIV_ROUND_EN: 0x3EAAAAAB, done after edge 29.
- Sign and divide-by-zero:
  - -10.0/5.0: 0xC1200000/0x40A00000 -> result=0xC0000000.
  - 1.0/0.0: 0x3F800000/0x00000000 -> result=0x7F800000, flag_dz=1, done after edge 2.
- Overflow/underflow:
  - 0x7F000000/0x00800000 -> result=0x7F800000, flag_of=1.
  - 0x00800000/0x7F000000 -> result=0x00000000, flag_uf=1.
- Handshake: second start asserted during cycles 5-20 of an operation is ignored. Result and done of the first op are unchanged; exactly one done pulse.
- Reset mid-op: assert rst asynchronously (off-edge) at cycle 10 -> busy/done/result/flags go to 0 immediately, FSM idles, and a subsequent start completes normally.
